// File: rtl/alarm_tone_decoder_if.sv
`timescale 1ns/1ps
// Interface bundle for alarm_tone_decoder: enable and audio line towards the
// decoder, tone measurement results back to the consumer.
interface alarm_tone_decoder_if #(
  parameter int PERIOD_W = 20
);
  logic                en;
  logic                audio_in;
  logic [PERIOD_W-1:0] half_period;
  logic                locked;
  logic                tone_start;
  logic                tone_end;
  logic [4:0]          tone_eighths;
  logic                silence;

  modport master (
    output en, audio_in,
    input  half_period, locked, tone_start, tone_end, tone_eighths, silence
  );

  modport slave (
    input  en, audio_in,
    output half_period, locked, tone_start, tone_end, tone_eighths, silence
  );
endinterface

// File: rtl/alarm_tone_decoder.sv
`timescale 1ns/1ps
// alarm_tone_decoder: samples a square-wave audio line, measures its
// half-period in clk cycles, locks onto stable tones and reports each tone's
// half-period and duration in eighth-second units.
// Build option: define GLITCH_FILTER_EN to insert a deglitch stage after the
// synchronizer (level must differ for 4 consecutive cycles before it moves).
module alarm_tone_decoder #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int PERIOD_W       = 20,
  parameter int STABLE_CNT     = 4,
  parameter int TOL_SHIFT      = 4,
  parameter int SILENCE_CYCLES = 2_000_000,
  parameter int DUR_DIV        = CLK_FREQ / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alarm_tone_decoder_if.slave  bus
);

  // The edge counter must be able to reach SILENCE_CYCLES even when that
  // exceeds the half-period width; measurements are clamped to PERIOD_W.
  localparam int SIL_W  = $clog2(SILENCE_CYCLES + 1);
  localparam int CNT_W  = (SIL_W > PERIOD_W) ? SIL_W : PERIOD_W;
  localparam int TICK_W = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [4:0] sat_inc_eighths(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  function automatic logic [PERIOD_W-1:0] sat_meas(input logic [CNT_W-1:0] v);
    if (v > CNT_W'({PERIOD_W{1'b1}})) return {PERIOD_W{1'b1}};
    return v[PERIOD_W-1:0];
  endfunction

  function automatic logic [PERIOD_W-1:0] abs_diff(input logic [PERIOD_W-1:0] a,
                                                   input logic [PERIOD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic                aud_p0, aud_p1, aud_p2;
  logic                lvl;
  logic                edge_det;
  logic [CNT_W-1:0]    hp_cnt_q;
  logic [PERIOD_W-1:0] meas;
  logic                in_tol;
  logic                timeout;

  state_t              state_q, state_d;
  logic                first_q, first_d;
  logic [3:0]          match_q, match_d;
  logic [PERIOD_W-1:0] ref_q, ref_d;

  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [4:0]          eighths_q, eighths_d;
  logic [PERIOD_W-1:0] half_period_q, half_period_d;
  logic                locked_q, locked_d;
  logic                tone_start_q, tone_start_d;
  logic                tone_end_q, tone_end_d;

  // --- stage p0/p1: two-flop synchronizer for the asynchronous audio line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aud_p0 <= 1'b0;
      aud_p1 <= 1'b0;
    end else if (!bus.en) begin
      aud_p0 <= 1'b0;
      aud_p1 <= 1'b0;
    end else begin
      aud_p0 <= bus.audio_in;
      aud_p1 <= aud_p0;
    end
  end

`ifdef GLITCH_FILTER_EN
  logic       filt_q;
  logic [1:0] gcnt_q;

  // Deglitch: follow the synchronized level only after it differs for 4 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      gcnt_q <= 2'd0;
    end else if (!bus.en) begin
      filt_q <= 1'b0;
      gcnt_q <= 2'd0;
    end else if (aud_p1 != filt_q) begin
      if (gcnt_q == 2'd3) begin
        filt_q <= aud_p1;
        gcnt_q <= 2'd0;
      end else begin
        gcnt_q <= gcnt_q + 2'd1;
      end
    end else begin
      gcnt_q <= 2'd0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = aud_p1;
`endif

  // --- stage p2: delayed level for edge detection (both polarities)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          aud_p2 <= 1'b0;
    else if (!bus.en) aud_p2 <= 1'b0;
    else              aud_p2 <= lvl;
  end

  assign edge_det = lvl ^ aud_p2;

  // Half-period counter: restarts on every edge, saturates while silent
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           hp_cnt_q <= '0;
    else if (!bus.en)  hp_cnt_q <= '0;
    else if (edge_det) hp_cnt_q <= '0;
    else               hp_cnt_q <= sat_inc_cnt(hp_cnt_q);
  end

  assign meas    = sat_meas(hp_cnt_q);
  assign in_tol  = abs_diff(meas, ref_q) <= (ref_q >> TOL_SHIFT);
  assign timeout = hp_cnt_q >= CNT_W'(SILENCE_CYCLES);

  // FSM state register together with acquisition bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      match_q <= 4'd0;
      ref_q   <= '0;
    end else if (!bus.en) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      match_q <= 4'd0;
      ref_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      match_q <= match_d;
      ref_q   <= ref_d;
    end
  end

  // Next state: silence timeout wins; an edge arriving with it restarts acquisition
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    match_d = match_q;
    ref_d   = ref_q;
    if (timeout) begin
      if (edge_det) begin
        state_d = ACQUIRE;
        first_d = 1'b1;
        match_d = 4'd0;
      end else begin
        state_d = IDLE;
      end
    end else if (edge_det) begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          first_d = 1'b1;
          match_d = 4'd0;
        end
        ACQUIRE: begin
          if (first_q) begin
            ref_d   = meas;
            match_d = 4'd1;
            first_d = 1'b0;
          end else if (in_tol) begin
            match_d = match_q + 4'd1;
          end else begin
            ref_d   = meas;
            match_d = 4'd1;
          end
          if (match_d == 4'(STABLE_CNT)) state_d = LOCKED;
        end
        LOCKED: begin
          // Reference is frozen while locked; only a far-off edge breaks lock
          if (!in_tol) begin
            state_d = ACQUIRE;
            ref_d   = meas;
            match_d = 4'd1;
            first_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: lock/unlock pulses from state transitions, duration ticking while locked
  always_comb begin
    half_period_d = half_period_q;
    locked_d      = (state_d == LOCKED);
    tone_start_d  = (state_q != LOCKED) && (state_d == LOCKED);
    tone_end_d    = (state_q == LOCKED) && (state_d != LOCKED);
    tick_d        = tick_q;
    eighths_d     = eighths_q;
    if (tone_start_d) begin
      half_period_d = ref_d;
      tick_d        = '0;
      eighths_d     = 5'd0;
    end else if (state_q == LOCKED) begin
      if (tick_q == TICK_W'(DUR_DIV - 1)) begin
        tick_d    = '0;
        eighths_d = sat_inc_eighths(eighths_q);
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  // Output and duration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_period_q <= '0;
      locked_q      <= 1'b0;
      tone_start_q  <= 1'b0;
      tone_end_q    <= 1'b0;
      tick_q        <= '0;
      eighths_q     <= 5'd0;
    end else if (!bus.en) begin
      half_period_q <= '0;
      locked_q      <= 1'b0;
      tone_start_q  <= 1'b0;
      tone_end_q    <= 1'b0;
      tick_q        <= '0;
      eighths_q     <= 5'd0;
    end else begin
      half_period_q <= half_period_d;
      locked_q      <= locked_d;
      tone_start_q  <= tone_start_d;
      tone_end_q    <= tone_end_d;
      tick_q        <= tick_d;
      eighths_q     <= eighths_d;
    end
  end

  assign bus.half_period  = half_period_q;
  assign bus.locked       = locked_q;
  assign bus.tone_start   = tone_start_q;
  assign bus.tone_end     = tone_end_q;
  assign bus.tone_eighths = eighths_q;
  assign bus.silence      = (state_q == IDLE);

endmodule

// File: tb/tb_alarm_tone_decoder.sv
`timescale 1ns/1ps
// Directed testbench for alarm_tone_decoder with shortened silence timeout
// (1000 cycles) and duration tick (200 cycles).
module tb_alarm_tone_decoder;

  localparam int SETTLE = 5;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   ts_cnt   = 0;
  int   te_cnt   = 0;

  alarm_tone_decoder_if #(.PERIOD_W(20)) bus ();

  alarm_tone_decoder #(
    .PERIOD_W      (20),
    .SILENCE_CYCLES(1000),
    .DUR_DIV       (200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse counters and start/end exclusivity, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.tone_start) ts_cnt++;
    if (bus.tone_end)   te_cnt++;
    if (bus.tone_start && bus.tone_end) check("start_end_same_cycle", 32'd1, 32'd0);
  end

  // One half-period: toggle after hp cycles measured from the previous toggle,
  // then return SETTLE cycles later so results are visible.
  task automatic half(input int hp);
    repeat (hp - SETTLE) @(posedge clk);
    #1 bus.audio_in = ~bus.audio_in;
    repeat (SETTLE) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_half_period"}, 32'(bus.half_period), 0);
    check({pfx, "_locked"}, 32'(bus.locked), 0);
    check({pfx, "_tone_start"}, 32'(bus.tone_start), 0);
    check({pfx, "_tone_end"}, 32'(bus.tone_end), 0);
    check({pfx, "_eighths"}, 32'(bus.tone_eighths), 0);
    check({pfx, "_silence"}, 32'(bus.silence), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int jit[8];
    int base_ts;
    int base_te;
    bit seen;
    jit = '{95, 105, 104, 96, 100, 99, 101, 95};

    rst = 1'b1;
    bus.en = 1'b1;
    bus.audio_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("rst");

    // Lock on a 100-cycle half-period
    repeat (5) half(100);
    check("lock_locked", 32'(bus.locked), 1);
    check("lock_half_period", 32'(bus.half_period), 99);
    check("lock_start_count", ts_cnt, 1);
    check("lock_silence", 32'(bus.silence), 0);

    // +/-5 cycle jitter stays within tolerance 6
    foreach (jit[i]) half(jit[i]);
    check("jit_locked", 32'(bus.locked), 1);
    check("jit_half_period", 32'(bus.half_period), 99);
    check("jit_no_end", te_cnt, 0);

    // Switch to 150-cycle half-periods: unlock, then relock at 149
    half(150);
    check("sw_end_count", te_cnt, 1);
    check("sw_unlocked", 32'(bus.locked), 0);
    repeat (4) half(150);
    check("sw_relocked", 32'(bus.locked), 1);
    check("sw_half_period", 32'(bus.half_period), 149);
    check("sw_start_count", ts_cnt, 2);

    // Synchronous clear via en
    bus.en = 1'b0;
    bus.audio_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("en");
    bus.en = 1'b1;

    // Lock, stay locked for 1000 cycles, then go silent
    repeat (5) half(100);
    check("tm_locked", 32'(bus.locked), 1);
    check("tm_start_count", ts_cnt, 3);
    repeat (10) half(100);
    base_te = te_cnt;
    seen = 1'b0;
    for (int c = 0; c < 1200 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (te_cnt != base_te) seen = 1'b1;
    end
    check("tm_end_seen", 32'(seen), 1);
    check("tm_end_count", te_cnt, base_te + 1);
    check("tm_silence", 32'(bus.silence), 1);
    check("tm_unlocked", 32'(bus.locked), 0);
    check("tm_eighths", 32'(bus.tone_eighths), 10);
    check("tm_hp_held", 32'(bus.half_period), 99);
    repeat (300) @(posedge clk);
    #1;
    check("hold_eighths", 32'(bus.tone_eighths), 10);
    check("hold_end_count", te_cnt, base_te + 1);
    check("hold_silence", 32'(bus.silence), 1);

    // Asynchronous reset in the middle of a locked, toggling tone
    fork
      repeat (8) half(100);
      begin
        repeat (650) @(posedge clk);
        #2;
        check("ar_locked_before", 32'(bus.locked), 1);
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
      end
    join
    bus.audio_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 2-cycle glitches in the middle of every 100-cycle half-period
    base_ts = ts_cnt;
    for (int k = 0; k < 10; k++) begin
      repeat (50) @(posedge clk);
      #1 bus.audio_in = ~bus.audio_in;
      repeat (2) @(posedge clk);
      #1 bus.audio_in = ~bus.audio_in;
      repeat (48) @(posedge clk);
      #1 bus.audio_in = ~bus.audio_in;
    end
    repeat (10) @(posedge clk);
    #1;
`ifdef GLITCH_FILTER_EN
    check("gl_locked", 32'(bus.locked), 1);
    check("gl_half_period", 32'(bus.half_period), 99);
    check("gl_start_count", ts_cnt, base_ts + 1);
`else
    check("gl_not_locked", 32'(bus.locked), 0);
    check("gl_half_period", 32'(bus.half_period), 0);
    check("gl_start_count", ts_cnt, base_ts);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
